// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the mouse receiver path.
//   tx_state_t      : transmitter state encoding
//   TX_DATA_OFS     : offset of the write-only TX data register from the block base address
//   STATUS_OFS      : offset of the read/clear STATUS register from the block base address
//   STAT_*          : bit positions inside the STATUS byte
//   odd_parity()    : parity bit that makes a PS/2 data byte plus parity carry an odd count of ones
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } tx_state_t;

    localparam logic [7:0] TX_DATA_OFS = 8'd0;
    localparam logic [7:0] STATUS_OFS  = 8'd1;

    localparam int STAT_BUSY    = 7;
    localparam int STAT_DONE    = 6;
    localparam int STAT_NACK    = 5;
    localparam int STAT_TIMEOUT = 4;
    localparam int STAT_OVERRUN = 3;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_io_if.sv
// Processor-side control signals of the PS/2 host transmitter.
//   BUS_ADDR            : processor address
//   BUS_WE              : processor write enable
//   BUS_INTERRUPT_RAISE : level interrupt request from the block
//   BUS_INTERRUPT_ACK   : interrupt acknowledge from the processor
// The tri-state data bus stays a plain inout port on the block.
interface ps2_host_tx_io_if;

    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output BUS_INTERRUPT_ACK,
        input  BUS_INTERRUPT_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_INTERRUPT_ACK,
        output BUS_INTERRUPT_RAISE
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines, plus falling-edge
// detection on the synchronized clock.
//   CLK, RESET  : system clock, synchronous active-low reset
//   clk_line    : raw PS/2 clock line
//   data_line   : raw PS/2 data line
//   clk_sync    : synchronized PS/2 clock
//   data_sync   : synchronized PS/2 data
//   clk_fall    : one-cycle pulse on a synchronized clock falling edge
module ps2_line_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic clk_line,
    input  logic data_line,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle PS/2 lines are high, so the chain starts at 1 to avoid a false edge after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_line};
            data_ff  <= {data_ff[0], data_line};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx_io.sv
// Bus-mapped PS/2 host-to-device transmitter.
//   CLK, RESET  : system clock, synchronous active-low reset
//   bus         : address, write enable, interrupt raise/ack (ps2_host_tx_io_if.slave)
//   BUS_DATA    : processor data bus; driven only in the cycle after a STATUS read
//   CLK_MOUSE   : PS/2 clock, open drain (0 or Z)
//   DATA_MOUSE  : PS/2 data, open drain (0 or Z)
// Registers: TX_DATA (write, BASE_ADDR+0) starts a frame; STATUS (BASE_ADDR+1)
// reads {busy, done, nack, timeout, overrun, 3'b000}; any write to it clears
// the four sticky flags.
module ps2_host_tx_io
    import ps2_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR      = 8'hA8,
    parameter int         INHIBIT_CYCLES = 5000,
    parameter int         TIMEOUT_CYCLES = 750000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    ps2_host_tx_io_if.slave       bus,
    inout  wire  [7:0]            BUS_DATA,
    inout  wire                   CLK_MOUSE,
    inout  wire                   DATA_MOUSE
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       TX_ADDR  = BASE_ADDR + TX_DATA_OFS;
    localparam logic [7:0]       ST_ADDR  = BASE_ADDR + STATUS_OFS;

    tx_state_t        state;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame;      // {stop, parity, data}, shifted out LSB first
    logic             clk_low;
    logic             data_low;
    logic             done;
    logic             nack;
    logic             timeout;
    logic             overrun;
    logic             irq;
    logic             rd_oe;
    logic [7:0]       rd_data;
    logic [7:0]       status_now;

    logic [7:0] bus_data_in;
    logic       clk_sync;
    logic       data_sync;
    logic       clk_fall;
    logic       busy;
    logic       tx_wr;
    logic       st_wr;
    logic       st_rd;
    logic       to_armed;

    ps2_line_sync u_line_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .clk_line  (CLK_MOUSE),
        .data_line (DATA_MOUSE),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    assign bus_data_in = BUS_DATA;
    assign busy        = (state != ST_IDLE);
    assign tx_wr       = bus.BUS_WE && (bus.BUS_ADDR == TX_ADDR);
    assign st_wr       = bus.BUS_WE && (bus.BUS_ADDR == ST_ADDR);
    assign st_rd       = !bus.BUS_WE && (bus.BUS_ADDR == ST_ADDR);
    // The ACK timeout runs from the clock release until the line returns to idle.
    assign to_armed    = busy && (state != ST_INHIBIT);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        status_now               = '0;
        status_now[STAT_BUSY]    = busy;
        status_now[STAT_DONE]    = done;
        status_now[STAT_NACK]    = nack;
        status_now[STAT_TIMEOUT] = timeout;
        status_now[STAT_OVERRUN] = overrun;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            clk_low  <= 1'b0;
            data_low <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
            irq      <= 1'b0;
            rd_oe    <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_oe   <= st_rd;
            rd_data <= status_now;

            // NOTE: clears and acks are written before the FSM, so a completion later in this
            // block overrides them in the same cycle (last non-blocking assignment wins).
            if (st_wr) begin
                done    <= 1'b0;
                nack    <= 1'b0;
                timeout <= 1'b0;
                overrun <= 1'b0;
            end
            if (tx_wr && busy) begin
                overrun <= 1'b1;
            end
            if (bus.BUS_INTERRUPT_ACK) begin
                irq <= 1'b0;
            end

            if (to_armed && (to_cnt == TO_LIMIT)) begin
                clk_low  <= 1'b0;
                data_low <= 1'b0;
                timeout  <= 1'b1;
                done     <= 1'b1;
                irq      <= 1'b1;
                state    <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tx_wr) begin
                            frame    <= {1'b1, odd_parity(bus_data_in), bus_data_in};
                            inh_cnt  <= '0;
                            clk_low  <= 1'b1;
                            data_low <= (INHIBIT_CYCLES == 1);
                            state    <= ST_INHIBIT;
                        end
                    end

                    ST_INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            // Clock released while the start bit is held low: request-to-send.
                            clk_low <= 1'b0;
                            bit_cnt <= '0;
                            to_cnt  <= '0;
                            state   <= ST_REQ;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                            // Start bit goes low during the final inhibit cycle.
                            if (inh_cnt + 1'b1 == INH_LAST) begin
                                data_low <= 1'b1;
                            end
                        end
                    end

                    ST_REQ: begin
                        to_cnt <= to_cnt + 1'b1;
                        state  <= ST_SHIFT;
                    end

                    ST_SHIFT: begin
                        to_cnt <= to_cnt + 1'b1;
                        if (clk_fall) begin
                            // Falls 1..10 present data[0..7], parity, then release for the stop bit.
                            data_low <= ~frame[bit_cnt];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) begin
                                state <= ST_ACK;
                            end
                        end
                    end

                    ST_ACK: begin
                        to_cnt <= to_cnt + 1'b1;
                        if (clk_fall) begin
                            nack  <= data_sync;
                            state <= ST_WAIT_IDLE;
                        end
                    end

                    ST_WAIT_IDLE: begin
                        to_cnt <= to_cnt + 1'b1;
                        if (clk_sync && data_sync) begin
                            done  <= 1'b1;
                            irq   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end

                    default: begin
                        clk_low  <= 1'b0;
                        data_low <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign CLK_MOUSE               = clk_low  ? 1'b0 : 1'bz;
    assign DATA_MOUSE              = data_low ? 1'b0 : 1'bz;
    assign BUS_DATA                = rd_oe ? rd_data : 8'hzz;
    assign bus.BUS_INTERRUPT_RAISE = irq;

endmodule

// File: tb/tb_ps2_host_tx_io.sv
// Self-checking bench for ps2_host_tx_io: a PS/2 device model answers each
// host request, and expected frames and STATUS bytes are queued when stimulus
// is issued and compared by the device model and a bus read monitor.
module tb_ps2_host_tx_io;
    import ps2_pkg::*;

    localparam logic [7:0] BASE      = 8'hA8;
    localparam logic [7:0] IDLE_ADDR = 8'h00;
    localparam int         INH       = 40;
    localparam int         TOUT      = 2500;
    localparam int         BUDGET    = INH + TOUT + 200;

    typedef enum logic [1:0] {DEV_ACK, DEV_NACK, DEV_SILENT, DEV_ABORT4} dev_mode_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    ps2_host_tx_io_if bif ();

    wire [7:0] BUS_DATA;
    wire       CLK_MOUSE;
    wire       DATA_MOUSE;

    logic       tb_oe        = 1'b0;
    logic [7:0] tb_dout      = 8'h00;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    assign BUS_DATA   = tb_oe ? tb_dout : 8'hzz;
    assign CLK_MOUSE  = dev_clk_low  ? 1'b0 : 1'bz;
    assign DATA_MOUSE = dev_data_low ? 1'b0 : 1'bz;
    pullup (CLK_MOUSE);
    pullup (DATA_MOUSE);

    ps2_host_tx_io #(
        .BASE_ADDR      (BASE),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .bus        (bif),
        .BUS_DATA   (BUS_DATA),
        .CLK_MOUSE  (CLK_MOUSE),
        .DATA_MOUSE (DATA_MOUSE)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] exp_frame_q[$];
    logic [7:0]  exp_status_q[$];

    dev_mode_t dev_mode    = DEV_ACK;
    int        dev_half    = 14;
    logic      dev_at_abort = 1'b0;

    // Reference status flags, updated from the outcome of each scenario.
    logic m_done = 1'b0, m_nack = 1'b0, m_timeout = 1'b0, m_overrun = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Wire-order frame: start, data LSB first, parity making the ones count odd, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f    = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones  += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic logic [7:0] model_status(input logic busy);
        return {busy, m_done, m_nack, m_timeout, m_overrun, 3'b000};
    endfunction

    task automatic model_clear();
        m_done    = 1'b0;
        m_nack    = 1'b0;
        m_timeout = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge CLK);
        bif.BUS_ADDR = addr;
        bif.BUS_WE   = 1'b1;
        tb_dout      = data;
        tb_oe        = 1'b1;
        @(negedge CLK);
        bif.BUS_WE   = 1'b0;
        tb_oe        = 1'b0;
        bif.BUS_ADDR = IDLE_ADDR;
    endtask

    task automatic read_status(input logic [7:0] exp);
        exp_status_q.push_back(exp);
        @(negedge CLK);
        bif.BUS_ADDR = BASE + 8'd1;
        bif.BUS_WE   = 1'b0;
        @(negedge CLK);
        bif.BUS_ADDR = IDLE_ADDR;
    endtask

    task automatic clear_status();
        bus_write(BASE + 8'd1, 8'h00);
        model_clear();
    endtask

    task automatic send(input logic [7:0] b, input dev_mode_t mode);
        dev_mode = mode;
        if (mode == DEV_ACK || mode == DEV_NACK) exp_frame_q.push_back(model_frame(b));
        bus_write(BASE, b);
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (bif.BUS_INTERRUPT_RAISE !== 1'b1 && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_irq_raised"}, 32'(bif.BUS_INTERRUPT_RAISE), 1);
    endtask

    task automatic irq_ack(input string tag);
        @(negedge CLK);
        bif.BUS_INTERRUPT_ACK = 1'b1;
        @(negedge CLK);
        bif.BUS_INTERRUPT_ACK = 1'b0;
        check({tag, "_irq_acked"}, 32'(bif.BUS_INTERRUPT_RAISE), 0);
    endtask

    // Full exchange: send, wait for completion, check STATUS, ack and clear.
    task automatic exchange(input logic [7:0] b, input dev_mode_t mode, input string tag);
        send(b, mode);
        wait_irq(tag);
        m_done = 1'b1;
        if (mode == DEV_NACK)   m_nack    = 1'b1;
        if (mode == DEV_SILENT) m_timeout = 1'b1;
        read_status(model_status(1'b0));
        irq_ack(tag);
        clear_status();
    endtask

    // STATUS read monitor: a read address seen at one edge is answered in the next cycle.
    logic rd_seen = 1'b0;
    always @(posedge CLK) rd_seen <= RESET && !bif.BUS_WE && (bif.BUS_ADDR == BASE + 8'd1);

    always @(negedge CLK) begin
        if (rd_seen) begin
            check("status_expected", 32'(exp_status_q.size() > 0), 1);
            if (exp_status_q.size() > 0) check("status_read", 32'(BUS_DATA), 32'(exp_status_q.pop_front()));
        end
    end

    // PS/2 device model: answers a request-to-send (clock released, data low).
    initial begin : device
        logic [10:0] got;
        int          npulse;
        forever begin
            @(negedge CLK);
            if (RESET && CLK_MOUSE == 1'b1 && DATA_MOUSE == 1'b0) begin
                if (dev_mode == DEV_SILENT) begin
                    while (DATA_MOUSE == 1'b0) @(negedge CLK);
                end else begin
                    npulse = (dev_mode == DEV_ABORT4) ? 4 : 10;
                    repeat (dev_half) @(negedge CLK);
                    got    = '0;
                    got[0] = DATA_MOUSE;
                    for (int k = 1; k <= npulse; k++) begin
                        dev_clk_low = 1'b1;
                        repeat (dev_half) @(negedge CLK);
                        dev_clk_low = 1'b0;
                        @(negedge CLK);
                        got[k] = DATA_MOUSE;
                        repeat (dev_half - 1) @(negedge CLK);
                    end
                    if (dev_mode == DEV_ABORT4) begin
                        dev_at_abort = 1'b1;
                        while (dev_at_abort) @(negedge CLK);
                    end else begin
                        if (dev_mode == DEV_ACK) dev_data_low = 1'b1;
                        repeat (2) @(negedge CLK);
                        dev_clk_low = 1'b1;
                        repeat (dev_half) @(negedge CLK);
                        dev_clk_low = 1'b0;
                        repeat (dev_half) @(negedge CLK);
                        dev_data_low = 1'b0;
                        check("frame_expected", 32'(exp_frame_q.size() > 0), 1);
                        if (exp_frame_q.size() > 0) check("frame_bits", 32'(got), 32'(exp_frame_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : main
        int lo;
        int n;
        logic [7:0] b;
        bif.BUS_ADDR          = IDLE_ADDR;
        bif.BUS_WE            = 1'b0;
        bif.BUS_INTERRUPT_ACK = 1'b0;

        // Reset state.
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_irq", 32'(bif.BUS_INTERRUPT_RAISE), 0);
        check("rst_clk_line", 32'(CLK_MOUSE), 1);
        check("rst_data_line", 32'(DATA_MOUSE), 1);
        RESET = 1'b1;
        @(negedge CLK);
        read_status(model_status(1'b0));

        // 0xF4 with ACK: frame bits, STATUS 0x40, interrupt raised then dropped by ack.
        dev_half = 14;
        exchange(8'hF4, DEV_ACK, "f4");

        // 0xFF: parity 1, clock held low for exactly the inhibit time.
        dev_mode = DEV_ACK;
        exp_frame_q.push_back(model_frame(8'hFF));
        bus_write(BASE, 8'hFF);
        lo = 0;
        while (CLK_MOUSE == 1'b0 && lo < INH + 20) begin
            lo++;
            @(negedge CLK);
        end
        check("inhibit_len", 32'(lo), 32'(INH));
        wait_irq("ff");
        m_done = 1'b1;
        read_status(model_status(1'b0));
        irq_ack("ff");
        clear_status();

        // NACK: device leaves data high at the ACK clock.
        exchange(8'h5A, DEV_NACK, "nack");

        // Timeout: device never clocks.
        send(8'hF4, DEV_SILENT);
        wait_irq("tout");
        m_done    = 1'b1;
        m_timeout = 1'b1;
        check("tout_clk_line", 32'(CLK_MOUSE), 1);
        check("tout_data_line", 32'(DATA_MOUSE), 1);
        read_status(model_status(1'b0));
        irq_ack("tout");
        clear_status();
        read_status(model_status(1'b0));

        // Write while busy: second byte dropped, overrun set.
        dev_half = 14;
        send(8'hF3, DEV_ACK);
        repeat (INH + 100) @(negedge CLK);
        bus_write(BASE, 8'h64);
        m_overrun = 1'b1;
        read_status(model_status(1'b1));
        wait_irq("ovr");
        m_done = 1'b1;
        read_status(model_status(1'b0));
        irq_ack("ovr");
        clear_status();
        read_status(model_status(1'b0));

        // Reset after the 4th falling edge abandons the frame.
        send(8'hF4, DEV_ABORT4);
        n = 0;
        while (!dev_at_abort && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        check("abort_reached", 32'(dev_at_abort), 1);
        check("abort_data_driven", 32'(DATA_MOUSE), 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_clk_line", 32'(CLK_MOUSE), 1);
        check("abort_data_line", 32'(DATA_MOUSE), 1);
        check("abort_irq", 32'(bif.BUS_INTERRUPT_RAISE), 0);
        RESET = 1'b1;
        model_clear();
        dev_at_abort = 1'b0;
        repeat (dev_half * 2) @(negedge CLK);
        read_status(model_status(1'b0));
        exchange(8'hF4, DEV_ACK, "post_rst");

        // Randomized bytes, device timing and ACK/NACK responses.
        for (int i = 0; i < 6; i++) begin
            b        = 8'($urandom);
            dev_half = int'($urandom_range(8, 20));
            exchange(b, ($urandom_range(0, 3) == 0) ? DEV_NACK : DEV_ACK, $sformatf("rnd%0d", i));
        end

        repeat (50) @(negedge CLK);
        check("frames_left", 32'(exp_frame_q.size()), 0);
        check("status_left", 32'(exp_status_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
